// File: rtl/boreal_weight_arbiter_if.sv
// Bundle of the requester and BRAM signals around boreal_weight_arbiter.
//  slave  : the arbiter side (takes requests and read data, drives grants,
//           returned data and the BRAM address/write ports).
//  master : the requesters/BRAM side.
// Signals: freeze; inf_* (inference read); lrn_* (learn RMW); dbg_* (debug
// read); mem_* (BRAM port A read / port B write); lrn_busy; abort_cnt.
interface boreal_weight_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  freeze;
    logic                  inf_req;
    logic [ADDR_WIDTH-1:0] inf_addr;
    logic                  inf_gnt;
    logic                  inf_rvalid;
    logic [DATA_WIDTH-1:0] inf_rdata;
    logic                  lrn_req;
    logic [ADDR_WIDTH-1:0] lrn_addr;
    logic                  lrn_gnt;
    logic                  lrn_old_valid;
    logic [DATA_WIDTH-1:0] lrn_old;
    logic                  lrn_new_valid;
    logic [DATA_WIDTH-1:0] lrn_new;
    logic                  dbg_req;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_dout_a;
    logic                  mem_we_b;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_din_b;
    logic                  lrn_busy;
    logic [7:0]            abort_cnt;

    modport slave (
        input  freeze, inf_req, inf_addr, lrn_req, lrn_addr, lrn_new_valid, lrn_new,
               dbg_req, dbg_addr, mem_dout_a,
        output inf_gnt, inf_rvalid, inf_rdata, lrn_gnt, lrn_old_valid, lrn_old,
               dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr_a, mem_we_b, mem_addr_b,
               mem_din_b, lrn_busy, abort_cnt
    );

    modport master (
        output freeze, inf_req, inf_addr, lrn_req, lrn_addr, lrn_new_valid, lrn_new,
               dbg_req, dbg_addr, mem_dout_a,
        input  inf_gnt, inf_rvalid, inf_rdata, lrn_gnt, lrn_old_valid, lrn_old,
               dbg_gnt, dbg_rvalid, dbg_rdata, mem_addr_a, mem_we_b, mem_addr_b,
               mem_din_b, lrn_busy, abort_cnt
    );
endinterface

// File: rtl/boreal_weight_arbiter.sv
// boreal_weight_arbiter: shares the synaptic weight BRAM between the inference
// core (read), the Hebbian learning engine (read-modify-write) and the debug
// host (read). One grant per cycle, priority inf > lrn > dbg with a starvation
// escape for learn, a read-after-write hazard stall on the learn address, the
// safety freeze and a timeout on the learn write-back.
// Ports:
//  clk  system clock
//  rst  synchronous reset, active-high
//  bus  boreal_weight_arbiter_if.slave (requests, grants, read data, BRAM ports,
//       lrn_busy, abort_cnt)
// Timing: request sampled at edge N -> grant + mem_addr_a after N -> data
// (*_rvalid / lrn_old_valid, rdata = mem_dout_a) after N+1.
module boreal_weight_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int LRN_TIMEOUT  = 16
) (
    input logic                    clk,
    input logic                    rst,
    boreal_weight_arbiter_if.slave bus
);
    typedef enum logic [1:0] {L_IDLE, L_RD, L_WAIT, L_WR} lrn_state_t;

    lrn_state_t            state;
    logic [ADDR_WIDTH-1:0] lrn_addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_a_q, mem_addr_b_q;
    logic [DATA_WIDTH-1:0] mem_din_b_q;
    logic                  mem_we_q;
    logic [7:0]            starve_cnt, wait_cnt, abort_cnt_q;
    logic                  inf_gnt_q, lrn_gnt_q, dbg_gnt_q;
    logic                  inf_rv_q, lrn_rv_q, dbg_rv_q;

    logic busy, inf_elig, lrn_elig, dbg_elig;
    logic take_inf, take_lrn, take_dbg;
    logic do_abort;

    // The hazard window covers L_RD..L_WR, so a blocked reader is only
    // granted once the write has landed in the BRAM.
    assign busy     = (state != L_IDLE);
    assign inf_elig = bus.inf_req && !(busy && bus.inf_addr == lrn_addr_q);
    assign dbg_elig = bus.dbg_req && !(busy && bus.dbg_addr == lrn_addr_q);
    assign lrn_elig = bus.lrn_req && !bus.freeze && (state == L_IDLE);

    assign take_lrn = lrn_elig && (!inf_elig || starve_cnt >= 8'(STARVE_LIMIT));
    assign take_inf = inf_elig && !take_lrn;
    assign take_dbg = dbg_elig && !inf_elig && !lrn_elig;

    // Abort wins over a same-cycle lrn_new_valid.
    assign do_abort = bus.freeze ||
                      ((state == L_WAIT) && (wait_cnt == 8'(LRN_TIMEOUT - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= L_IDLE;
            lrn_addr_q   <= '0;
            mem_addr_a_q <= '0;
            mem_addr_b_q <= '0;
            mem_din_b_q  <= '0;
            mem_we_q     <= 1'b0;
            starve_cnt   <= '0;
            wait_cnt     <= '0;
            abort_cnt_q  <= '0;
            inf_gnt_q    <= 1'b0;
            lrn_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            inf_rv_q     <= 1'b0;
            lrn_rv_q     <= 1'b0;
            dbg_rv_q     <= 1'b0;
        end else begin
            inf_gnt_q <= take_inf;
            lrn_gnt_q <= take_lrn;
            dbg_gnt_q <= take_dbg;
            inf_rv_q  <= inf_gnt_q;
            // lrn_gnt_q is high exactly while in L_RD; drop the data pulse
            // if that RMW is being aborted by freeze.
            lrn_rv_q  <= lrn_gnt_q && !bus.freeze;
            dbg_rv_q  <= dbg_gnt_q;

            if (take_inf)      mem_addr_a_q <= bus.inf_addr;
            else if (take_lrn) mem_addr_a_q <= bus.lrn_addr;
            else if (take_dbg) mem_addr_a_q <= bus.dbg_addr;

            // Counts inf grants issued while learn is kept waiting.
            if (!bus.lrn_req || take_lrn)
                starve_cnt <= '0;
            else if (take_inf && starve_cnt != 8'hFF)
                starve_cnt <= starve_cnt + 8'd1;

            mem_we_q <= 1'b0;
            case (state)
                L_IDLE: begin
                    if (take_lrn) begin
                        state      <= L_RD;
                        lrn_addr_q <= bus.lrn_addr;
                    end
                end
                L_RD: begin
                    wait_cnt <= '0;
                    if (bus.freeze) begin
                        state <= L_IDLE;
                        if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
                    end else begin
                        state <= L_WAIT;
                    end
                end
                L_WAIT: begin
                    if (do_abort) begin
                        state <= L_IDLE;
                        if (abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 8'd1;
                    end else if (bus.lrn_new_valid) begin
                        state        <= L_WR;
                        mem_we_q     <= 1'b1;
                        mem_addr_b_q <= lrn_addr_q;
                        mem_din_b_q  <= bus.lrn_new;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= L_IDLE;  // L_WR: write pulse already issued
            endcase
        end
    end

    assign bus.inf_gnt       = inf_gnt_q;
    assign bus.lrn_gnt       = lrn_gnt_q;
    assign bus.dbg_gnt       = dbg_gnt_q;
    assign bus.inf_rvalid    = inf_rv_q;
    assign bus.lrn_old_valid = lrn_rv_q;
    assign bus.dbg_rvalid    = dbg_rv_q;
    // Read data is gated so idle/reset outputs are all zero.
    assign bus.inf_rdata     = inf_rv_q ? bus.mem_dout_a : '0;
    assign bus.lrn_old       = lrn_rv_q ? bus.mem_dout_a : '0;
    assign bus.dbg_rdata     = dbg_rv_q ? bus.mem_dout_a : '0;
    assign bus.mem_addr_a    = mem_addr_a_q;
    assign bus.mem_we_b      = mem_we_q;
    assign bus.mem_addr_b    = mem_addr_b_q;
    assign bus.mem_din_b     = mem_din_b_q;
    assign bus.lrn_busy      = busy;
    assign bus.abort_cnt     = abort_cnt_q;
endmodule

// File: tb/tb_boreal_weight_arbiter.sv
module tb_boreal_weight_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;

    always #5 clk = ~clk;

    boreal_weight_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    boreal_weight_arbiter #(
        .ADDR_WIDTH(10), .DATA_WIDTH(16), .STARVE_LIMIT(8), .LRN_TIMEOUT(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_abort = 0;

    logic [15:0] inf_q[$];
    logic [15:0] lrn_q[$];
    logic [15:0] dbg_q[$];
    logic [25:0] wr_q[$];
    logic [15:0] mon_e;
    logic [25:0] mon_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [9:0] a);
        case (a)
            10'd3:   return 16'h0333;
            10'd5:   return 16'h1234;
            10'd7:   return 16'h0100;
            10'd9:   return 16'h0999;
            default: return ({6'd0, a} * 16'h0011) ^ 16'hA000;
        endcase
    endfunction

    // BRAM model: port A 1-cycle registered read, port B write.
    logic [15:0] mem [1024];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(10'(i));
            bus.mem_dout_a <= '0;
        end else begin
            bus.mem_dout_a <= mem[bus.mem_addr_a];
            if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_din_b;
        end
    end

    // Scoreboard: every returned word / write is matched against the queue.
    always @(negedge clk) begin
        if (!mem_load) begin
            chk("onehot", 32'($countones({bus.inf_gnt, bus.lrn_gnt, bus.dbg_gnt}) <= 1), 1);
            if (bus.inf_rvalid) begin
                if (inf_q.size() == 0) chk("inf_unexpected", 1, 0);
                else begin mon_e = inf_q.pop_front(); chk("inf_rdata", 32'(bus.inf_rdata), 32'(mon_e)); end
            end
            if (bus.lrn_old_valid) begin
                if (lrn_q.size() == 0) chk("lrn_old_unexpected", 1, 0);
                else begin mon_e = lrn_q.pop_front(); chk("lrn_old", 32'(bus.lrn_old), 32'(mon_e)); end
            end
            if (bus.dbg_rvalid) begin
                if (dbg_q.size() == 0) chk("dbg_unexpected", 1, 0);
                else begin mon_e = dbg_q.pop_front(); chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(mon_e)); end
            end
            if (bus.mem_we_b) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin mon_w = wr_q.pop_front(); chk("wr_addr_data", 32'({bus.mem_addr_b, bus.mem_din_b}), 32'(mon_w)); end
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.inf_gnt;
            1:       return bus.lrn_gnt;
            2:       return bus.dbg_gnt;
            3:       return bus.lrn_old_valid;
            default: return !bus.lrn_busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(which)) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic inf_rd(input logic [9:0] a, input logic [15:0] exp);
        inf_q.push_back(exp);
        bus.inf_addr = a;
        bus.inf_req  = 1'b1;
        wait_for(0, "inf_gnt_timeout", 30);
        bus.inf_req  = 1'b0;
    endtask

    // Returns at the negedge where lrn_old_valid is seen (first L_WAIT cycle).
    task automatic lrn_start(input logic [9:0] a, input logic [15:0] old_exp);
        lrn_q.push_back(old_exp);
        bus.lrn_addr = a;
        bus.lrn_req  = 1'b1;
        wait_for(1, "lrn_gnt_timeout", 30);
        bus.lrn_req  = 1'b0;
        wait_for(3, "lrn_old_timeout", 3);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnts"},   32'({bus.inf_gnt, bus.lrn_gnt, bus.dbg_gnt}), 0);
        chk({tag, "_valids"}, 32'({bus.inf_rvalid, bus.lrn_old_valid, bus.dbg_rvalid}), 0);
        chk({tag, "_rdata"},  32'(bus.inf_rdata | bus.lrn_old | bus.dbg_rdata), 0);
        chk({tag, "_we"},     32'(bus.mem_we_b), 0);
        chk({tag, "_addr_a"}, 32'(bus.mem_addr_a), 0);
        chk({tag, "_port_b"}, 32'({bus.mem_addr_b, bus.mem_din_b}), 0);
        chk({tag, "_busy"},   32'(bus.lrn_busy), 0);
        chk({tag, "_abort"},  32'(bus.abort_cnt), 0);
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.freeze = 0; bus.inf_req = 0; bus.inf_addr = '0;
        bus.lrn_req = 0; bus.lrn_addr = '0; bus.lrn_new_valid = 0; bus.lrn_new = '0;
        bus.dbg_req = 0; bus.dbg_addr = '0;
        @(negedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // 1) plain inference read, 2-cycle latency
        inf_q.push_back(16'h1234);
        bus.inf_addr = 10'd5; bus.inf_req = 1'b1;
        wait_for(0, "t1_gnt_timeout", 1);
        chk("t1_gnt_lat", 32'(bus.inf_gnt), 1);
        bus.inf_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid_lat", 32'(bus.inf_rvalid), 1);
        drain();

        // 2) learn RMW then read-back
        lrn_start(10'd7, 16'h0100);
        repeat (2) @(negedge clk);
        wr_q.push_back({10'd7, 16'h0110});
        bus.lrn_new = 16'h0110; bus.lrn_new_valid = 1'b1;
        @(negedge clk);
        bus.lrn_new_valid = 1'b0;
        wait_for(4, "t2_idle_timeout", 5);
        inf_rd(10'd7, 16'h0110);
        drain();

        // 3) starvation escape: 8 inf grants, 1 lrn grant, inf resumes, no dbg
        repeat (11) inf_q.push_back(init_val(10'd20));
        lrn_q.push_back(init_val(10'd30));
        bus.inf_addr = 10'd20; bus.lrn_addr = 10'd30; bus.dbg_addr = 10'd40;
        bus.inf_req = 1'b1; bus.lrn_req = 1'b1; bus.dbg_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t3_inf_gnt", 32'(bus.inf_gnt), 32'(c != 9));
            chk("t3_lrn_gnt", 32'(bus.lrn_gnt), 32'(c == 9));
            chk("t3_dbg_gnt", 32'(bus.dbg_gnt), 0);
            if (c == 9) bus.lrn_req = 1'b0;
        end
        bus.inf_req = 1'b0; bus.dbg_req = 1'b0;
        wr_q.push_back({10'd30, 16'hBEEF});
        bus.lrn_new = 16'hBEEF; bus.lrn_new_valid = 1'b1;
        @(negedge clk);
        bus.lrn_new_valid = 1'b0;
        wait_for(4, "t3_idle_timeout", 5);
        drain();

        // 4) hazard: inf on the learn address stalls, dbg elsewhere proceeds
        lrn_start(10'd3, 16'h0333);
        inf_q.push_back(16'h0334);
        dbg_q.push_back(16'h0999);
        bus.inf_addr = 10'd3; bus.inf_req = 1'b1;
        bus.dbg_addr = 10'd9; bus.dbg_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t4_inf_stall", 32'(bus.inf_gnt), 0);
            chk("t4_dbg_gnt", 32'(bus.dbg_gnt), 32'(k == 1));
            if (k == 1) bus.dbg_req = 1'b0;
        end
        wr_q.push_back({10'd3, 16'h0334});
        bus.lrn_new = 16'h0334; bus.lrn_new_valid = 1'b1;
        @(negedge clk);
        bus.lrn_new_valid = 1'b0;
        chk("t4_we", 32'(bus.mem_we_b), 1);
        chk("t4_inf_stall_wr", 32'(bus.inf_gnt), 0);
        @(negedge clk);
        chk("t4_inf_stall_post", 32'(bus.inf_gnt), 0);
        @(negedge clk);
        chk("t4_inf_release", 32'(bus.inf_gnt), 1);
        bus.inf_req = 1'b0;
        drain();

        // 6a) freeze together with lrn_new_valid in L_WAIT -> abort, no write
        lrn_start(10'd60, init_val(10'd60));
        bus.freeze = 1'b1; bus.lrn_new = 16'hDEAD; bus.lrn_new_valid = 1'b1;
        @(negedge clk);
        bus.freeze = 1'b0; bus.lrn_new_valid = 1'b0;
        exp_abort = 1;
        chk("t6_freeze_busy", 32'(bus.lrn_busy), 0);
        chk("t6_freeze_abort", 32'(bus.abort_cnt), 32'(exp_abort));
        drain();

        // 6b) freeze held with lrn_req -> no lrn grant
        bus.freeze = 1'b1; bus.lrn_addr = 10'd61; bus.lrn_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t6_freeze_gnt", 32'(bus.lrn_gnt), 0);
        end
        bus.lrn_req = 1'b0; bus.freeze = 1'b0;
        drain();

        // 5) learn timeout, then saturation of abort_cnt
        for (int it = 1; it <= 300; it++) begin
            lrn_start(10'd50, init_val(10'd50));
            if (it == 1) begin
                for (int k = 2; k <= 16; k++) begin
                    @(negedge clk);
                    chk("t5_wait_busy", 32'(bus.lrn_busy), 1);
                end
                @(negedge clk);
                chk("t5_timeout_idle", 32'(bus.lrn_busy), 0);
            end else begin
                repeat (16) @(negedge clk);
            end
            exp_abort = (exp_abort == 255) ? 255 : exp_abort + 1;
            chk("t5_abort_cnt", 32'(bus.abort_cnt), 32'(exp_abort));
        end
        drain();

        // 6c) reset in the cycle before L_WR -> no write, outputs cleared
        lrn_start(10'd70, init_val(10'd70));
        bus.lrn_new = 16'hCAFE; bus.lrn_new_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("t6_rst");
        rst = 1'b0; bus.lrn_new_valid = 1'b0;
        drain();
        inf_rd(10'd70, init_val(10'd70));
        drain();

        chk("inf_q_empty", 32'(inf_q.size()), 0);
        chk("lrn_q_empty", 32'(lrn_q.size()), 0);
        chk("dbg_q_empty", 32'(dbg_q.size()), 0);
        chk("wr_q_empty",  32'(wr_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
